// File: rtl/mandelbrot_dispatcher.sv
// Purpose : walks a frame in raster order, hands one c value at a time to an
//           iteration engine and forwards each result downstream as a pixel.
// Latency : ISSUE(1) + SETTLE(1) + engine cycles in WAIT + OUTPUT(>=1) per pixel.
// Backpr. : OUTPUT holds pix_valid and all pix_* fields until pix_ready; no new
//           engine_start is issued while a pixel is waiting for pix_ready.
//
// Ports
//   clk, rst                   single rising-edge clock, synchronous active-high reset
//   frame_start                request one frame scan (only honoured while idle)
//   x_min, y_max, step         left-edge real, top-edge imaginary, per-pixel increment
//   engine_start               one-cycle start pulse to the iteration engine
//   engine_c_real/_imaginary   c value of the pixel currently being computed
//   engine_valid, engine_is_mandelbrot, engine_iterations   engine result
//   pix_valid/pix_ready        downstream handshake
//   pix_x, pix_y, pix_iterations, pix_in_set                 pixel payload
//   busy                       high whenever the scanner is not idle
//   frame_done                 one-cycle pulse after the last pixel transfers
module mandelbrot_dispatcher #(
   parameter int FIXED_POINT_WIDTH = 16,
   parameter int MAX_ITER          = 256,
   parameter int H_RES             = 64,
   parameter int V_RES             = 48,
   localparam int IW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1,
   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1,
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                frame_start,
   input  logic signed [FIXED_POINT_WIDTH-1:0] x_min,
   input  logic signed [FIXED_POINT_WIDTH-1:0] y_max,
   input  logic signed [FIXED_POINT_WIDTH-1:0] step,
   output logic                                engine_start,
   output logic signed [FIXED_POINT_WIDTH-1:0] engine_c_real,
   output logic signed [FIXED_POINT_WIDTH-1:0] engine_c_imaginary,
   input  logic                                engine_valid,
   input  logic                                engine_is_mandelbrot,
   input  logic [IW-1:0]                       engine_iterations,
   output logic                                pix_valid,
   input  logic                                pix_ready,
   output logic [XW-1:0]                       pix_x,
   output logic [YW-1:0]                       pix_y,
   output logic [IW-1:0]                       pix_iterations,
   output logic                                pix_in_set,
   output logic                                busy,
   output logic                                frame_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_OUTPUT = 3'd4;

   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

   logic [2:0]                          state_q,      state_d;
   logic [XW-1:0]                       x_q,          x_d;
   logic [YW-1:0]                       y_q,          y_d;
   logic signed [FIXED_POINT_WIDTH-1:0] c_real_q,     c_real_d;
   logic signed [FIXED_POINT_WIDTH-1:0] c_imag_q,     c_imag_d;
   logic signed [FIXED_POINT_WIDTH-1:0] x_min_q,      x_min_d;
   logic signed [FIXED_POINT_WIDTH-1:0] step_q,       step_d;
   logic [XW-1:0]                       pix_x_q,      pix_x_d;
   logic [YW-1:0]                       pix_y_q,      pix_y_d;
   logic [IW-1:0]                       pix_iter_q,   pix_iter_d;
   logic                                pix_in_set_q, pix_in_set_d;
   logic                                frame_done_q, frame_done_d;

   logic x_last;
   logic y_last;

   assign x_last = (x_q == X_LAST);
   assign y_last = (y_q == Y_LAST);

   // Control outputs are decoded straight from the state register, so they are
   // glitch-free and automatically confined to their owning state.
   assign engine_start       = (state_q == S_ISSUE);
   assign pix_valid          = (state_q == S_OUTPUT);
   assign busy               = (state_q != S_IDLE);
   assign frame_done         = frame_done_q;
   assign engine_c_real      = c_real_q;
   assign engine_c_imaginary = c_imag_q;
   assign pix_x              = pix_x_q;
   assign pix_y              = pix_y_q;
   assign pix_iterations     = pix_iter_q;
   assign pix_in_set         = pix_in_set_q;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      c_real_d     = c_real_q;
      c_imag_d     = c_imag_q;
      x_min_d      = x_min_q;
      step_d       = step_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_iter_d   = pix_iter_q;
      pix_in_set_d = pix_in_set_q;
      frame_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Frame parameters are captured only here, so later changes on
            // x_min/y_max/step (or another frame_start) cannot disturb a scan.
            if (frame_start) begin
               x_min_d  = x_min;
               step_d   = step;
               x_d      = '0;
               y_d      = '0;
               c_real_d = x_min;
               c_imag_d = y_max;
               state_d  = S_ISSUE;
            end
         end

         S_ISSUE: begin
            state_d = S_SETTLE;
         end

         // engine_valid may still be high from the previous pixel's result
         // during this cycle, so it is deliberately not looked at here.
         S_SETTLE: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (engine_valid) begin
               pix_iter_d   = engine_iterations;
               pix_in_set_d = engine_is_mandelbrot;
               pix_x_d      = x_q;
               pix_y_d      = y_q;
               state_d      = S_OUTPUT;
            end
         end

         S_OUTPUT: begin
            if (pix_ready) begin
               if (!x_last) begin
                  x_d      = x_q + 1'b1;
                  c_real_d = c_real_q + step_q;   // wraps modulo 2^W by design
                  state_d  = S_ISSUE;
               end else if (!y_last) begin
                  x_d      = '0;
                  y_d      = y_q + 1'b1;
                  c_real_d = x_min_q;
                  c_imag_d = c_imag_q - step_q;   // rows go downward in imaginary
                  state_d  = S_ISSUE;
               end else begin
                  frame_done_d = 1'b1;
                  state_d      = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         c_real_q     <= '0;
         c_imag_q     <= '0;
         x_min_q      <= '0;
         step_q       <= '0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_iter_q   <= '0;
         pix_in_set_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         c_real_q     <= c_real_d;
         c_imag_q     <= c_imag_d;
         x_min_q      <= x_min_d;
         step_q       <= step_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_iter_q   <= pix_iter_d;
         pix_in_set_q <= pix_in_set_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_mandelbrot_dispatcher.sv
// Bench for mandelbrot_dispatcher on a 4x2 frame with a 3-cycle engine model.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected c values come from c = (x_min + x*step, y_max - y*step) mod 2^16.
module tb_mandelbrot_dispatcher;
   localparam int FW = 16;
   localparam int MI = 256;
   localparam int HR = 4;
   localparam int VR = 2;
   localparam int IW = 8;
   localparam int XW = 2;
   localparam int YW = 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 frame_start;
   logic signed [FW-1:0] x_min, y_max, step;
   logic                 engine_start;
   logic signed [FW-1:0] engine_c_real, engine_c_imaginary;
   logic                 engine_valid;
   logic                 engine_is_mandelbrot;
   logic [IW-1:0]        engine_iterations;
   logic                 pix_valid;
   logic                 pix_ready;
   logic [XW-1:0]        pix_x;
   logic [YW-1:0]        pix_y;
   logic [IW-1:0]        pix_iterations;
   logic                 pix_in_set;
   logic                 busy;
   logic                 frame_done;

   int errors = 0;
   int checks = 0;
   int eng_cnt = 0;
   bit stale_en = 1'b0;
   int done_cnt = 0;
   logic [8:0] res_q[$];   // {in_set, iterations} handed out by the engine model

   mandelbrot_dispatcher #(
      .FIXED_POINT_WIDTH(FW), .MAX_ITER(MI), .H_RES(HR), .V_RES(VR)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .x_min(x_min), .y_max(y_max), .step(step),
      .engine_start(engine_start),
      .engine_c_real(engine_c_real), .engine_c_imaginary(engine_c_imaginary),
      .engine_valid(engine_valid), .engine_is_mandelbrot(engine_is_mandelbrot),
      .engine_iterations(engine_iterations),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_iterations(pix_iterations),
      .pix_in_set(pix_in_set), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Engine model: answers 3 cycles after engine_start with a random result;
   // optionally drives a junk result during the cycle right after the start.
   initial begin
      logic [7:0] r_it;
      logic       r_set;
      engine_valid = 1'b0; engine_iterations = '0; engine_is_mandelbrot = 1'b0;
      forever begin
         @(negedge clk);
         engine_valid = 1'b0;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               r_it  = 8'($urandom_range(0, 164));
               r_set = 1'($urandom_range(0, 1));
               engine_valid = 1'b1; engine_iterations = r_it; engine_is_mandelbrot = r_set;
               res_q.push_back({r_set, r_it});
            end else if (eng_cnt == 2 && stale_en) begin
               engine_valid = 1'b1; engine_iterations = 8'hA5; engine_is_mandelbrot = 1'b1;
            end
         end
         if (engine_start) eng_cnt = 3;
      end
   end

   // frame_done pulse counter (value seen before each rising edge)
   initial forever begin
      @(posedge clk);
      if (frame_done === 1'b1) done_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running need finished");
      $fatal(1, "watchdog");
   end

   // One pixel: check c at engine_start, follow it to OUTPUT, check the payload,
   // optionally stall pix_ready for 'hold' cycles, then let it transfer.
   task automatic do_pixel(input int px, input int py, input logic [15:0] ecr,
                           input logic [15:0] eci, input int hold, input bit poke,
                           input string tag);
      int n;
      bit stable, extra;
      logic [8:0] exp_r;
      logic [XW-1:0] ex;
      logic [YW-1:0] ey;
      ex = XW'(px);
      ey = YW'(py);
      n = 0;
      while (engine_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (engine_start !== 1'b1) begin
         errors++;
         $display("FAIL %s start_timeout (%0d,%0d): engine_start=%b need 1", tag, px, py, engine_start);
         return;
      end
      checks++;
      if (engine_c_real !== ecr) begin
         errors++;
         $display("FAIL %s c_real (%0d,%0d): got %h need %h", tag, px, py, engine_c_real, ecr);
      end
      checks++;
      if (engine_c_imaginary !== eci) begin
         errors++;
         $display("FAIL %s c_imag (%0d,%0d): got %h need %h", tag, px, py, engine_c_imaginary, eci);
      end
      if (poke) begin
         frame_start = 1'b1; x_min = 16'h1234; y_max = 16'h4321; step = 16'h0111;
      end
      n = 0; stable = 1'b1; extra = 1'b0;
      do begin
         @(negedge clk);
         n++;
         frame_start = 1'b0;
         if (pix_valid !== 1'b1) begin
            if (engine_c_real !== ecr || engine_c_imaginary !== eci) stable = 1'b0;
            if (engine_start !== 1'b0) extra = 1'b1;
         end
      end while (pix_valid !== 1'b1 && n < 40);
      checks++;
      if (pix_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s pix_valid_timeout (%0d,%0d): pix_valid=%b need 1", tag, px, py, pix_valid);
         return;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL %s c_stable (%0d,%0d): c moved before result, need %h/%h", tag, px, py, ecr, eci);
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL %s extra_start (%0d,%0d): engine_start seen again, need 0", tag, px, py);
      end
      checks++;
      if (res_q.size() == 0) begin
         errors++;
         $display("FAIL %s no_result (%0d,%0d): queue empty, need 1 entry", tag, px, py);
         return;
      end
      exp_r = res_q.pop_front();
      checks++;
      if (pix_x !== ex || pix_y !== ey) begin
         errors++;
         $display("FAIL %s pix_xy: got (%0d,%0d) need (%0d,%0d)", tag, pix_x, pix_y, ex, ey);
      end
      checks++;
      if (pix_iterations !== exp_r[7:0] || pix_in_set !== exp_r[8]) begin
         errors++;
         $display("FAIL %s pix_result (%0d,%0d): got it=%0d set=%b need it=%0d set=%b",
                  tag, px, py, pix_iterations, pix_in_set, exp_r[7:0], exp_r[8]);
      end
      if (hold > 0) begin
         pix_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (pix_valid !== 1'b1 || pix_x !== ex || pix_y !== ey || pix_iterations !== exp_r[7:0] ||
                pix_in_set !== exp_r[8] || engine_start !== 1'b0) begin
               errors++;
               $display("FAIL %s hold_cycle%0d: got v=%b x=%0d y=%0d it=%0d set=%b start=%b need v=1 x=%0d y=%0d it=%0d set=%b start=0",
                        tag, i, pix_valid, pix_x, pix_y, pix_iterations, pix_in_set, engine_start,
                        ex, ey, exp_r[7:0], exp_r[8]);
            end
         end
         pix_ready = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic start_frame(input logic [15:0] xm, input logic [15:0] ym, input logic [15:0] st);
      x_min = xm; y_max = ym; step = st; frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   // Full frame against the raster model; hold_idx/poke_idx select a pixel
   // for backpressure or a mid-frame frame_start (-1 disables).
   task automatic run_frame(input logic [15:0] xm, input logic [15:0] ym, input logic [15:0] st,
                            input int hold_idx, input int poke_idx, input string tag);
      int d0;
      logic [15:0] cr, ci;
      d0 = done_cnt;
      start_frame(xm, ym, st);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_start: got %b need 1", tag, busy);
      end
      for (int y = 0; y < VR; y++) begin
         for (int x = 0; x < HR; x++) begin
            cr = xm + 16'(x) * st;
            ci = ym - 16'(y) * st;
            do_pixel(x, y, cr, ci, (y * HR + x == hold_idx) ? 10 : 0,
                     (y * HR + x == poke_idx), tag);
         end
      end
      checks++;
      if (frame_done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s frame_end: got done=%b busy=%b need done=1 busy=0", tag, frame_done, busy);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL %s done_pulse: got done=%b pulses=%0d need done=0 pulses=1", tag, frame_done, done_cnt - d0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if (busy !== 1'b0 || engine_start !== 1'b0 || pix_valid !== 1'b0 || frame_done !== 1'b0 ||
          pix_x !== '0 || pix_y !== '0 || pix_iterations !== '0 || pix_in_set !== 1'b0 ||
          engine_c_real !== '0 || engine_c_imaginary !== '0) begin
         errors++;
         $display("FAIL %s zero_outputs: got busy=%b st=%b v=%b fd=%b x=%0d y=%0d it=%0d set=%b cr=%h ci=%h need all 0",
                  tag, busy, engine_start, pix_valid, frame_done, pix_x, pix_y, pix_iterations,
                  pix_in_set, engine_c_real, engine_c_imaginary);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_basic_frame;
      // Q4.12: -2.0, +1.0, 0.5
      run_frame(16'hE000, 16'h1000, 16'h0800, -1, -1, "basic");
   endtask

   task automatic test_back_to_back;
      run_frame(16'hE000, 16'h1000, 16'h0800, 2, -1, "backpressure");
   endtask

   task automatic test_stale_valid;
      stale_en = 1'b1;
      run_frame(16'hF000, 16'h0800, 16'h0400, -1, -1, "stale_valid");
      stale_en = 1'b0;
   endtask

   task automatic test_midframe_start;
      run_frame(16'hE800, 16'h0C00, 16'h0200, -1, 1, "midframe_start");
   endtask

   task automatic test_reset_midframe;
      int n, d0;
      logic [15:0] cr, ci;
      start_frame(16'hE000, 16'h1000, 16'h0800);
      for (int i = 0; i < 6; i++) begin
         cr = 16'hE000 + 16'(i % HR) * 16'h0800;
         ci = 16'h1000 - 16'(i / HR) * 16'h0800;
         do_pixel(i % HR, i / HR, cr, ci, 0, 1'b0, "rst_mid_pre");
      end
      n = 0;
      while (engine_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || pix_valid !== 1'b0 || engine_c_real !== 16'hF000) begin
         errors++;
         $display("FAIL rst_mid in_wait: got busy=%b v=%b cr=%h need busy=1 v=0 cr=f000", busy, pix_valid, engine_c_real);
      end
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("rst_mid");
      repeat (6) @(negedge clk);
      checks++;
      if (done_cnt !== d0 || busy !== 1'b0 || pix_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid aftermath: got pulses=%0d busy=%b v=%b need pulses=0 busy=0 v=0", done_cnt - d0, busy, pix_valid);
      end
      res_q.delete();
      run_frame(16'h0400, 16'hFC00, 16'h0100, -1, -1, "after_rst");
   endtask

   task automatic test_wrap;
      run_frame(16'h7FFF, 16'h0000, 16'h0001, -1, -1, "wrap");
   endtask

   task automatic test_random_frames;
      for (int f = 0; f < 4; f++) begin
         run_frame(16'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 9)) - 2, -1, "random");
      end
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; x_min = '0; y_max = '0; step = '0; pix_ready = 1'b1;
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_stale_valid();
      test_midframe_start();
      test_reset_midframe();
      test_wrap();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
